// File: rtl/alu_mdu_unit.sv
// Integer ALU with an iterative multiply/divide unit: single-cycle ALU ops and
// illegal decodes answer the next cycle; MUL/DIV families take XLEN iterations.
module alu_mdu_unit #(
  parameter int XLEN  = 32,
  parameter int M_EXT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_in,
  input  logic            kill,
  input  logic [1:0]      ALUOp,
  input  logic [2:0]      func3,
  input  logic [6:0]      func7,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [3:0]      ALUControl,
  output logic [XLEN-1:0] result,
  output logic            result_valid,
  output logic            busy,
  output logic            illegal,
  output logic [1:0]      dbg_state
);
  // valid_in is taken on a rising edge only when busy=0 and kill=0; nothing is
  // queued. result_valid is a one-cycle pulse; result/ALUControl hold until the next.
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  localparam logic [3:0] C_ADD = 4'b0000, C_SUB = 4'b0001, C_AND = 4'b0010,
                         C_OR  = 4'b0011, C_XOR = 4'b0100, C_SLT = 4'b0101,
                         C_SLTU = 4'b0110, C_MUL = 4'b1000, C_MULHU = 4'b1001,
                         C_DIV = 4'b1010, C_DIVU = 4'b1011, C_REM = 4'b1100,
                         C_REMU = 4'b1101, C_ILL = 4'b1111;
  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state_q, state_d;
  logic [3:0]      ctl_q, ctl_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            rv_q, rv_d, ill_q, ill_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, opb_q, opb_d;
  logic            qneg_q, qneg_d, rneg_q, rneg_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  function automatic logic [3:0] base_op(input logic [2:0] f3);
    case (f3)
      3'b000:  base_op = C_ADD;
      3'b100:  base_op = C_XOR;
      3'b110:  base_op = C_OR;
      3'b111:  base_op = C_AND;
      3'b010:  base_op = C_SLT;
      3'b011:  base_op = C_SLTU;
      default: base_op = C_ILL;
    endcase
  endfunction

  function automatic logic [3:0] m_op(input logic [2:0] f3);
    case (f3)
      3'b000:  m_op = C_MUL;
      3'b011:  m_op = C_MULHU;
      3'b100:  m_op = C_DIV;
      3'b101:  m_op = C_DIVU;
      3'b110:  m_op = C_REM;
      3'b111:  m_op = C_REMU;
      default: m_op = C_ILL;
    endcase
  endfunction

  logic [3:0] dec;
  always_comb begin
    dec = C_ILL;
    case (ALUOp)
      2'b00: dec = C_ADD;
      2'b01: dec = C_SUB;
      2'b10: begin
        if (func7 == 7'b0000000)                   dec = base_op(func3);
        else if (func7 == 7'b0100000 && func3 == 3'b000) dec = C_SUB;
        else if (func7 == 7'b0000001 && M_EXT == 1) dec = m_op(func3);
      end
      default: dec = base_op(func3);
    endcase
  end

  logic [XLEN-1:0] alu_res;
  always_comb begin
    alu_res = '0;
    case (dec)
      C_ADD:  alu_res = a + b;
      C_SUB:  alu_res = a - b;
      C_AND:  alu_res = a & b;
      C_OR:   alu_res = a | b;
      C_XOR:  alu_res = a ^ b;
      C_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      C_SLTU: alu_res = {{(XLEN-1){1'b0}}, (a < b)};
      default: alu_res = '0;
    endcase
  end

  // One shift-add step (hi:lo holds partial product, lo shifts out multiplier)
  // and one restoring-division step (hi = remainder, lo = quotient/dividend).
  logic [XLEN:0]   mul_sum, div_sh, div_trial;
  logic [XLEN-1:0] mul_hi_n, mul_lo_n, div_hi_n, div_lo_n;
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    mul_hi_n  = mul_sum[XLEN:1];
    mul_lo_n  = {mul_sum[0], lo_q[XLEN-1:1]};
    div_sh    = {hi_q, lo_q[XLEN-1]};
    div_trial = div_sh - {1'b0, opb_q};
    if (!div_trial[XLEN]) begin
      div_hi_n = div_trial[XLEN-1:0];
      div_lo_n = {lo_q[XLEN-2:0], 1'b1};
    end else begin
      div_hi_n = div_sh[XLEN-1:0];
      div_lo_n = {lo_q[XLEN-2:0], 1'b0};
    end
  end

  logic accept, is_signed_div, a_neg, b_neg, last_iter;
  always_comb begin
    state_d = state_q; ctl_d = ctl_q; result_d = result_q;
    rv_d = 1'b0; ill_d = 1'b0;
    hi_d = hi_q; lo_d = lo_q; opb_d = opb_q;
    qneg_d = qneg_q; rneg_d = rneg_q; cnt_d = cnt_q;
    accept        = valid_in && (state_q == S_IDLE) && !kill;
    is_signed_div = (dec == C_DIV) || (dec == C_REM);
    a_neg         = is_signed_div && a[XLEN-1];
    b_neg         = is_signed_div && b[XLEN-1];
    last_iter     = (cnt_q == CW'(XLEN-1));
    case (state_q)
      S_IDLE: if (accept) begin
        ctl_d = dec;
        case (dec)
          C_ILL: begin result_d = '0; ill_d = 1'b1; rv_d = 1'b1; end
          C_MUL, C_MULHU: begin
            hi_d = '0; lo_d = b; opb_d = a; cnt_d = '0; state_d = S_MUL;
          end
          C_DIV, C_DIVU, C_REM, C_REMU: begin
            if (b == '0) begin
              result_d = (dec == C_DIV || dec == C_DIVU) ? '1 : a;
              rv_d = 1'b1;
            end else if (is_signed_div && a == MOST_NEG && b == '1) begin
              result_d = (dec == C_DIV) ? a : '0;
              rv_d = 1'b1;
            end else begin
              hi_d = '0; lo_d = a_neg ? -a : a; opb_d = b_neg ? -b : b;
              qneg_d = a_neg ^ b_neg; rneg_d = a_neg; cnt_d = '0;
              state_d = S_DIV;
            end
          end
          default: begin result_d = alu_res; rv_d = 1'b1; end
        endcase
      end
      S_MUL: begin
        hi_d = mul_hi_n; lo_d = mul_lo_n; cnt_d = cnt_q + 1'b1;
        if (last_iter) begin
          result_d = (ctl_q == C_MULHU) ? mul_hi_n : mul_lo_n;
          rv_d = 1'b1; state_d = S_DONE;
        end
      end
      S_DIV: begin
        hi_d = div_hi_n; lo_d = div_lo_n; cnt_d = cnt_q + 1'b1;
        if (last_iter) begin
          if (ctl_q == C_DIV || ctl_q == C_DIVU)
            result_d = qneg_q ? -div_lo_n : div_lo_n;
          else
            result_d = rneg_q ? -div_hi_n : div_hi_n;
          rv_d = 1'b1; state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (kill && state_q != S_IDLE) begin
      state_d = S_IDLE; rv_d = 1'b0; result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE; ctl_q <= 4'b0000; result_q <= '0;
      rv_q <= 1'b0; ill_q <= 1'b0;
      hi_q <= '0; lo_q <= '0; opb_q <= '0;
      qneg_q <= 1'b0; rneg_q <= 1'b0; cnt_q <= '0;
    end else begin
      state_q <= state_d; ctl_q <= ctl_d; result_q <= result_d;
      rv_q <= rv_d; ill_q <= ill_d;
      hi_q <= hi_d; lo_q <= lo_d; opb_q <= opb_d;
      qneg_q <= qneg_d; rneg_q <= rneg_d; cnt_q <= cnt_d;
    end
  end

  // A kill seen during DONE suppresses that cycle's pulse.
  assign result_valid = rv_q && !(kill && state_q == S_DONE);
  assign illegal      = ill_q;
  assign ALUControl   = ctl_q;
  assign result       = result_q;
  assign busy         = (state_q != S_IDLE);
  assign dbg_state    = state_q;
endmodule

// File: tb/tb_alu_mdu_unit.sv
// Directed bench for alu_mdu_unit (XLEN=32) with a second M_EXT=0 instance.
module tb_alu_mdu_unit;
  logic        clk = 1'b0;
  logic        rst, valid_in, kill;
  logic [1:0]  ALUOp;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic [31:0] a, b;
  logic [3:0]  ctl, ctl0;
  logic [31:0] res, res0;
  logic        rv, rv0, busy, busy0, ill, ill0;
  logic [1:0]  st, st0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_mdu_unit #(.XLEN(32), .M_EXT(1)) u_dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .kill(kill), .ALUOp(ALUOp),
    .func3(func3), .func7(func7), .a(a), .b(b), .ALUControl(ctl),
    .result(res), .result_valid(rv), .busy(busy), .illegal(ill), .dbg_state(st));

  alu_mdu_unit #(.XLEN(32), .M_EXT(0)) u_dut0 (
    .clk(clk), .rst(rst), .valid_in(valid_in), .kill(kill), .ALUOp(ALUOp),
    .func3(func3), .func7(func7), .a(a), .b(b), .ALUControl(ctl0),
    .result(res0), .result_valid(rv0), .busy(busy0), .illegal(ill0), .dbg_state(st0));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drive one request on a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] xa, input logic [31:0] xb);
    @(negedge clk);
    ALUOp = op; func3 = f3; func7 = f7; a = xa; b = xb; valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  task automatic single(input string tag, input logic [1:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] xa, input logic [31:0] xb,
                        input logic [31:0] er, input logic [3:0] ec, input logic ei);
    issue(op, f3, f7, xa, xb);
    check({tag, ".rv"}, rv, 1'b1);
    check({tag, ".res"}, res, er);
    check({tag, ".ctl"}, ctl, ec);
    check({tag, ".ill"}, ill, ei);
    check({tag, ".busy"}, busy, 1'b0);
  endtask

  task automatic multi(input string tag, input logic [2:0] f3, input logic [31:0] xa,
                       input logic [31:0] xb, input logic [31:0] er, input logic [3:0] ec,
                       input bit inject);
    int lat, bcnt;
    issue(2'b10, f3, 7'b0000001, xa, xb);
    lat = 1; bcnt = 0;
    while (!rv && lat < 60) begin
      if (busy) bcnt++;
      if (inject && lat == 5) begin
        ALUOp = 2'b00; a = 32'd1; b = 32'd1; valid_in = 1'b1;
      end
      @(negedge clk);
      valid_in = 1'b0;
      lat++;
    end
    if (busy) bcnt++;
    check({tag, ".lat"}, lat, 33);
    check({tag, ".busy_cycles"}, bcnt, 33);
    check({tag, ".res"}, res, er);
    check({tag, ".ctl"}, ctl, ec);
    @(negedge clk);
    check({tag, ".idle_busy"}, busy, 1'b0);
    check({tag, ".no_extra_rv"}, rv, 1'b0);
  endtask

  initial begin
    int seen;
    rst = 1'b1; valid_in = 1'b0; kill = 1'b0;
    ALUOp = '0; func3 = '0; func7 = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("rst.res", res, 0);
    check("rst.ctl", ctl, 4'b0000);
    check("rst.rv", rv, 0);
    check("rst.busy", busy, 0);
    check("rst.ill", ill, 0);
    rst = 1'b0;

    single("st_add",  2'b00, 3'b111, 7'h7f, 32'd5, 32'd7, 32'd12, 4'b0000, 1'b0);
    single("br_sub",  2'b01, 3'b000, 7'h00, 32'd5, 32'd7, 32'hFFFFFFFE, 4'b0001, 1'b0);
    single("r_sub",   2'b10, 3'b000, 7'b0100000, 32'd5, 32'd7, 32'hFFFFFFFE, 4'b0001, 1'b0);
    single("r_xor",   2'b10, 3'b100, 7'h00, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 4'b0100, 1'b0);
    single("r_or",    2'b10, 3'b110, 7'h00, 32'h0000F000, 32'h0000000F, 32'h0000F00F, 4'b0011, 1'b0);
    single("r_and",   2'b10, 3'b111, 7'h00, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b0010, 1'b0);
    single("r_slt",   2'b10, 3'b010, 7'h00, 32'hFFFFFFFF, 32'd1, 32'd1, 4'b0101, 1'b0);
    single("r_sltu",  2'b10, 3'b011, 7'h00, 32'hFFFFFFFF, 32'd1, 32'd0, 4'b0110, 1'b0);
    single("i_add",   2'b11, 3'b000, 7'b0100000, 32'd10, 32'hFFFFFFFF, 32'd9, 4'b0000, 1'b0);
    single("i_slt",   2'b11, 3'b010, 7'h00, 32'd3, 32'd3, 32'd0, 4'b0101, 1'b0);
    single("r_ill3",  2'b10, 3'b001, 7'h00, 32'd5, 32'd7, 32'd0, 4'b1111, 1'b1);
    single("r_ill7",  2'b10, 3'b100, 7'b0100000, 32'd5, 32'd7, 32'd0, 4'b1111, 1'b1);
    @(negedge clk);
    check("pulse_end.rv", rv, 0);
    check("pulse_end.ill", ill, 0);
    check("hold.res", res, 0);
    check("hold.ctl", ctl, 4'b1111);

    multi("mulhu", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 4'b1001, 1'b0);
    multi("mul",   3'b000, 32'd6, 32'hFFFFFFF9, 32'hFFFFFFD6, 4'b1000, 1'b1);
    multi("div",   3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 4'b1010, 1'b0);
    multi("rem",   3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 4'b1100, 1'b0);
    multi("divu",  3'b101, 32'd100, 32'd7, 32'd14, 4'b1011, 1'b0);
    multi("remu",  3'b111, 32'd100, 32'd7, 32'd2, 4'b1101, 1'b0);

    single("divu0",  2'b10, 3'b101, 7'b0000001, 32'd1234, 32'd0, 32'hFFFFFFFF, 4'b1011, 1'b0);
    single("remu0",  2'b10, 3'b111, 7'b0000001, 32'd1234, 32'd0, 32'd1234, 4'b1101, 1'b0);
    single("div_ovf", 2'b10, 3'b100, 7'b0000001, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 4'b1010, 1'b0);
    single("rem_ovf", 2'b10, 3'b110, 7'b0000001, 32'h80000000, 32'hFFFFFFFF, 32'd0, 4'b1100, 1'b0);

    // kill mid-MUL: no pulse, then a fresh ADD is answered normally
    issue(2'b10, 3'b000, 7'b0000001, 32'd3, 32'd4);
    seen = 0;
    repeat (9) begin
      if (rv) seen++;
      @(negedge clk);
    end
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kill.busy", busy, 0);
    repeat (30) begin
      if (rv) seen++;
      @(negedge clk);
    end
    check("kill.no_rv", seen, 0);
    single("kill_add", 2'b00, 3'b000, 7'h00, 32'd1, 32'd1, 32'd2, 4'b0000, 1'b0);

    // kill alongside valid_in wins
    @(negedge clk);
    ALUOp = 2'b00; a = 32'd9; b = 32'd9; valid_in = 1'b1; kill = 1'b1;
    @(negedge clk);
    valid_in = 1'b0; kill = 1'b0;
    check("killv.rv", rv, 0);
    check("killv.ctl", ctl, 4'b0000);
    check("killv.res", res, 32'd2);

    // reset mid-DIV
    issue(2'b10, 3'b100, 7'b0000001, 32'd1000, 32'd3);
    repeat (5) @(negedge clk);
    check("rdiv.busy_pre", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rdiv.busy", busy, 0);
    check("rdiv.res", res, 0);
    check("rdiv.ctl", ctl, 4'b0000);
    check("rdiv.rv", rv, 0);

    // M op on the M_EXT=0 instance decodes illegal
    issue(2'b10, 3'b000, 7'b0000001, 32'd6, 32'd7);
    check("m0.rv", rv0, 1);
    check("m0.ill", ill0, 1);
    check("m0.res", res0, 0);
    check("m0.ctl", ctl0, 4'b1111);
    check("m0.busy", busy0, 0);
    check("m1.busy", busy, 1);
    repeat (40) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
